// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one syn_fifo write port among
// NUM_REQ valid/ready producers, with bounded bursts and a stall on FIFO full.
// Optional macro ARB_AF_YIELD_EN: an accepted beat while fifo_almost_full is
// high also ends the burst, so the remaining headroom goes to other requesters.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    logic [0:0]            r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [IDX_W-1:0]      r_last;
    logic [CNT_W-1:0]      r_beat_cnt;

    logic [0:0]            w_state_nxt;
    logic [NUM_REQ-1:0]    w_grant_nxt;
    logic [IDX_W-1:0]      w_last_nxt;
    logic [CNT_W-1:0]      w_beat_nxt;

    logic [IDX_W-1:0]      w_gidx;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_pick_found;
    logic                  w_sel_valid;
    logic                  w_accept;
    logic                  w_af_yield;
    logic [DATA_WIDTH-1:0] w_data;

`ifdef ARB_AF_YIELD_EN
    assign w_af_yield = fifo_almost_full;
`else
    logic w_unused_af;
    assign w_af_yield  = 1'b0;
    assign w_unused_af = fifo_almost_full;
`endif

    // One-hot grant to index, used when recording last_grant on release.
    always_comb begin
        w_gidx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) w_gidx = IDX_W'(i);
        end
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [IDX_W-1:0] idx;
        w_pick       = '0;
        w_pick_found = 1'b0;
        idx          = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((32'(r_last) + k) % NUM_REQ);
            if (!w_pick_found && req_valid[idx]) begin
                w_pick_found = 1'b1;
                w_pick       = idx;
            end
        end
    end

    // AND-OR data mux over the one-hot grant; zero when nothing is granted.
    always_comb begin
        w_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_data = w_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
        end
    end

    assign w_sel_valid = |(req_valid & r_grant);
    assign w_accept    = (r_state == S_BURST) && w_sel_valid && !fifo_full;

    // Next-state logic: arbitrate in IDLE, count beats and release in BURST.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found && !fifo_full) begin
                    w_state_nxt = S_BURST;
                    w_grant_nxt = NUM_REQ'(1) << w_pick;
                    w_beat_nxt  = '0;
                end
            end
            S_BURST: begin
                if (!w_sel_valid) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = w_gidx;
                end else if (!fifo_full) begin
                    if ((r_beat_cnt == LAST_BEAT) || w_af_yield) begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                        w_last_nxt  = w_gidx;
                        w_beat_nxt  = r_beat_cnt + CNT_W'(1);
                    end else begin
                        w_beat_nxt  = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State registers; reset clears the grant immediately so the port goes quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    assign req_ready    = fifo_full ? '0 : r_grant;
    assign fifo_wr_en   = w_accept;
    assign fifo_wr_data = w_data;
    assign grant        = r_grant;
    assign busy         = (r_state == S_BURST);

`ifndef SYNTHESIS
    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));
    a_no_wr_on_full: assert property (@(posedge clk) disable iff (rst) !(fifo_wr_en && fifo_full));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a grant/beat reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_almost_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic [NR-1:0]     grant;
    logic              busy;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .grant            (grant),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: granted requester (-1 = none), beats in burst, last winner.
    int m_g;
    int m_beats;
    int m_last;
    int cnt [NR];

    logic [DW-1:0] wq[$];
    logic [NR-1:0] gq[$];
    logic [NR-1:0] prev_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int r);
        return DW'(((r + 1) << 4) | ((cnt[r] + 1) & 15));
    endfunction

    task automatic set_data();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = beat_data(i);
    endtask

    task automatic model_reset();
        m_g     = -1;
        m_beats = 0;
        m_last  = NR - 1;
    endtask

    task automatic check_outputs(input string tag);
        logic [NR-1:0] e_grant;
        logic [NR-1:0] e_ready;
        logic          e_wr;
        logic [DW-1:0] e_data;
        e_grant = (m_g < 0) ? '0 : NR'(1 << m_g);
        e_ready = (m_g >= 0 && !fifo_full) ? e_grant : '0;
        e_wr    = (m_g >= 0) && req_valid[m_g] && !fifo_full;
        e_data  = (m_g >= 0) ? beat_data(m_g) : '0;
        check({tag, ".grant"}, 32'(grant), 32'(e_grant));
        check({tag, ".busy"},  32'(busy),  32'(m_g >= 0));
        check({tag, ".ready"}, 32'(req_ready), 32'(e_ready));
        check({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(e_wr));
        check({tag, ".data"},  32'(fifo_wr_data), 32'(e_data));
        if (fifo_wr_en) wq.push_back(fifo_wr_data);
        if (grant != '0 && prev_grant == '0) gq.push_back(grant);
        prev_grant = grant;
    endtask

    // Apply the arbitration rules for the upcoming rising edge.
    task automatic model_step();
        bit rel;
        rel = 1'b0;
        if (m_g < 0) begin
            if (req_valid != '0 && !fifo_full) begin
                for (int k = 1; k <= NR; k++) begin
                    if (m_g < 0 && req_valid[(m_last + k) % NR]) m_g = (m_last + k) % NR;
                end
                m_beats = 0;
            end
        end else if (!req_valid[m_g]) begin
            rel = 1'b1;
        end else if (!fifo_full) begin
            cnt[m_g]++;
            m_beats++;
            if (m_beats == MB) rel = 1'b1;
`ifdef ARB_AF_YIELD_EN
            if (fifo_almost_full) rel = 1'b1;
`endif
        end
        if (rel) begin
            m_last = m_g;
            m_g    = -1;
        end
    endtask

    task automatic cycle(input logic [NR-1:0] v, input logic f, input logic af, input string tag);
        @(negedge clk);
        req_valid        = v;
        fifo_full        = f;
        fifo_almost_full = af;
        set_data();
        #1;
        check_outputs(tag);
        model_step();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check({tag, ".rst_grant"}, 32'(grant), 32'(0));
        check({tag, ".rst_wr_en"}, 32'(fifo_wr_en), 32'(0));
        check({tag, ".rst_ready"}, 32'(req_ready), 32'(0));
        check({tag, ".rst_busy"},  32'(busy), 32'(0));
        req_valid        = '0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        model_reset();
        prev_grant = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int first_run;
        rst              = 1'b1;
        req_valid        = '0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        prev_grant       = '0;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        set_data();
        model_reset();
        #12;
        check("reset.grant", 32'(grant), 32'(0));
        check("reset.busy",  32'(busy), 32'(0));
        check("reset.wr_en", 32'(fifo_wr_en), 32'(0));
        check("reset.data",  32'(fifo_wr_data), 32'(0));
        check("reset.ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single requester streams one full burst.
        wq.delete();
        for (int c = 0; c < 5; c++) cycle(4'b0001, 1'b0, 1'b0, "t1");
        cycle(4'b0000, 1'b0, 1'b0, "t1_idle");
        check("t1.release", 32'(grant), 32'(0));
        check("t1.nbeats", 32'(wq.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            if (i < wq.size()) check("t1.wdata", 32'(wq[i]), 32'(8'h11 + i));

        // All requesters valid: rotating grants, one idle cycle between them.
        do_reset("t2");
        gq.delete();
        for (int c = 0; c < 25; c++) cycle(4'b1111, 1'b0, 1'b0, "t2");
        check("t2.ngrants", 32'(gq.size()), 32'(5));
        for (int i = 0; i < 5; i++)
            if (i < gq.size()) check("t2.order", 32'(gq[i]), 32'(1 << (i % 4)));

        // Stall on FIFO full in the middle of req 2's burst.
        cycle(4'b0000, 1'b0, 1'b0, "t3_idle");
        for (int c = 0; c < 3; c++) cycle(4'b0100, 1'b0, 1'b0, "t3_pre");
        for (int c = 0; c < 3; c++) begin
            cycle(4'b0100, 1'b1, 1'b0, "t3_full");
            check("t3.hold_grant", 32'(grant), 32'(4'b0100));
            check("t3.hold_wr",    32'(fifo_wr_en), 32'(0));
        end
        for (int c = 0; c < 2; c++) cycle(4'b0100, 1'b0, 1'b0, "t3_post");
        cycle(4'b0000, 1'b0, 1'b0, "t3_end");
        check("t3.release", 32'(grant), 32'(0));

        // Valid drop releases early; req 2 then wins over req 0.
        cycle(4'b0010, 1'b0, 1'b0, "t4");
        cycle(4'b0010, 1'b0, 1'b0, "t4");
        cycle(4'b0101, 1'b0, 1'b0, "t4_drop");
        cycle(4'b0101, 1'b0, 1'b0, "t4_idle");
        cycle(4'b0101, 1'b0, 1'b0, "t4_next");
        check("t4.rr_after_1", 32'(grant), 32'(4'b0100));
        cycle(4'b0000, 1'b0, 1'b0, "t4_end");

        // Reset mid-burst with req 3 granted; req 0 wins afterwards.
        cycle(4'b1000, 1'b0, 1'b0, "t5");
        cycle(4'b1000, 1'b0, 1'b0, "t5");
        check("t5.pre_grant", 32'(grant), 32'(4'b1000));
        do_reset("t5");
        cycle(4'b1111, 1'b0, 1'b0, "t5_arb");
        cycle(4'b1111, 1'b0, 1'b0, "t5_win");
        check("t5.first_after_rst", 32'(grant), 32'(4'b0001));

        // Almost-full at beat 2 of req 0 with req 1 also waiting.
        do_reset("t6");
        wq.delete();
        gq.delete();
        cycle(4'b0011, 1'b0, 1'b0, "t6");
        cycle(4'b0011, 1'b0, 1'b0, "t6");
        cycle(4'b0011, 1'b0, 1'b1, "t6_af");
        for (int c = 0; c < 9; c++) cycle(4'b0011, 1'b0, 1'b0, "t6");
        first_run = 0;
        while (first_run < wq.size() && wq[first_run][7:4] == 4'h1) first_run++;
`ifdef ARB_AF_YIELD_EN
        check("t6.req0_beats", 32'(first_run), 32'(2));
`else
        check("t6.req0_beats", 32'(first_run), 32'(4));
`endif
        if (gq.size() >= 2) check("t6.second_grant", 32'(gq[1]), 32'(4'b0010));
        else check("t6.ngrants", 32'(gq.size()), 32'(2));

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd");
            end else begin
                cycle(NR'($urandom), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 2) == 0), "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
